// File: rtl/pulse_peak_finder.sv
// pulse_peak_finder
//   Turns the sample stream of one shaping filter into one record per pulse:
//   peak amplitude, timestamp of the peak and time-over-threshold.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high
//   enable          1 = detection active; 0 drops any pulse in progress
//   threshold       signed trigger level, sampled every cycle
//   input_data      signed filter output, one sample per clk
//   peak_valid      one-cycle strobe, record outputs valid
//   peak_amplitude  largest sample of the pulse (first one wins on ties)
//   peak_time       free-running timestamp of that sample
//   peak_width      number of samples strictly above threshold
//   peak_overflow   pulse reached MAX_WIDTH samples
//   busy            registered, state != IDLE
//   event_count     records emitted since reset, wraps
module pulse_peak_finder #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIME_WIDTH     = 32,
   parameter int WIDTH_BITS     = 8,
   parameter int MAX_WIDTH      = 200,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic signed [DATA_WIDTH-1:0] threshold,
   input  logic signed [DATA_WIDTH-1:0] input_data,
   output logic                         peak_valid,
   output logic signed [DATA_WIDTH-1:0] peak_amplitude,
   output logic        [TIME_WIDTH-1:0] peak_time,
   output logic        [WIDTH_BITS-1:0] peak_width,
   output logic                         peak_overflow,
   output logic                         busy,
   output logic                  [15:0] event_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ABOVE    = 2'd1,
      WAIT_LOW = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   localparam int HOLD_BITS = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam state_t AFTER_PULSE = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
   localparam logic [WIDTH_BITS-1:0] MAX_W = WIDTH_BITS'(MAX_WIDTH);
   // Counter runs HOLDOFF_CYCLES-1 .. 0 so the exit happens on the last holdoff edge.
   localparam logic [HOLD_BITS-1:0] HOLD_LOAD =
      (HOLDOFF_CYCLES > 0) ? HOLD_BITS'(HOLDOFF_CYCLES - 1) : HOLD_BITS'(0);

   // Equal to threshold counts as below.
   function automatic logic is_above(input logic signed [DATA_WIDTH-1:0] s,
                                     input logic signed [DATA_WIDTH-1:0] t);
      return s > t;
   endfunction

   state_t                         state, state_nxt;
   logic        [TIME_WIDTH-1:0]   ts;
   logic signed [DATA_WIDTH-1:0]   max_amp, run_amp;
   logic        [TIME_WIDTH-1:0]   max_time, run_time;
   logic        [WIDTH_BITS-1:0]   width_cnt, width_inc, run_width;
   logic        [HOLD_BITS-1:0]    hold_cnt;
   logic                           above, track, emit, emit_ovf;

   assign above     = is_above(input_data, threshold);
   assign width_inc = width_cnt + WIDTH_BITS'(1);

   // run_* is the pulse summary including the current sample; it feeds both
   // the tracking registers and the record registers.
   always_comb begin
      state_nxt = state;
      track     = 1'b0;
      emit      = 1'b0;
      emit_ovf  = 1'b0;
      run_amp   = max_amp;
      run_time  = max_time;
      run_width = width_cnt;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (above) begin
                  run_amp   = input_data;
                  run_time  = ts;
                  run_width = WIDTH_BITS'(1);
                  if (MAX_WIDTH == 1) begin
                     emit      = 1'b1;
                     emit_ovf  = 1'b1;
                     state_nxt = WAIT_LOW;
                  end else begin
                     track     = 1'b1;
                     state_nxt = ABOVE;
                  end
               end
            end
            ABOVE: begin
               if (above) begin
                  track     = 1'b1;
                  run_width = width_inc;
                  if (input_data > max_amp) begin
                     run_amp  = input_data;
                     run_time = ts;
                  end
                  if (width_inc == MAX_W) begin
                     emit      = 1'b1;
                     emit_ovf  = 1'b1;
                     state_nxt = WAIT_LOW;
                  end
               end else begin
                  emit      = 1'b1;
                  state_nxt = AFTER_PULSE;
               end
            end
            WAIT_LOW: begin
               if (!above) state_nxt = AFTER_PULSE;
            end
            HOLDOFF: begin
               if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ts             <= '0;
         hold_cnt       <= '0;
         busy           <= 1'b0;
         peak_valid     <= 1'b0;
         peak_amplitude <= '0;
         peak_time      <= '0;
         peak_width     <= '0;
         peak_overflow  <= 1'b0;
         event_count    <= '0;
      end else begin
         state      <= state_nxt;
         ts         <= ts + TIME_WIDTH'(1);
         busy       <= (state_nxt != IDLE);
         peak_valid <= emit;
         if (state != HOLDOFF && state_nxt == HOLDOFF) begin
            hold_cnt <= HOLD_LOAD;
         end else if (state == HOLDOFF) begin
            hold_cnt <= hold_cnt - HOLD_BITS'(1);
         end
         if (emit) begin
            peak_amplitude <= run_amp;
            peak_time      <= run_time;
            peak_width     <= run_width;
            peak_overflow  <= emit_ovf;
            event_count    <= event_count + 16'd1;
         end
      end
   end

   // Pulse tracking registers are always written before being read, so they carry no reset.
   always_ff @(posedge clk) begin
      if (track) begin
         max_amp   <= run_amp;
         max_time  <= run_time;
         width_cnt <= run_width;
      end
   end

endmodule

// File: tb/tb_pulse_peak_finder.sv
// Bench for pulse_peak_finder: two instances share the inputs, one with
// MAX_WIDTH=8/HOLDOFF=16 and one with MAX_WIDTH=1/HOLDOFF=0, and a short
// timestamp so wrap-around happens often. A per-pulse reference model kept
// here predicts every output after every clock edge.
module tb_pulse_peak_finder;
   localparam int DW = 16;
   localparam int TW = 8;
   localparam int WB = 8;
   localparam int MAXW_A = 8;
   localparam int HOLD_A = 16;
   localparam int MAXW_B = 1;
   localparam int HOLD_B = 0;

   localparam int P_IDLE = 0, P_ABOVE = 1, P_WAIT = 2, P_HOLD = 3;

   logic clk = 1'b0;
   logic reset, enable;
   logic signed [DW-1:0] threshold, input_data;

   logic                 pv_a, ov_a, bsy_a, pv_b, ov_b, bsy_b;
   logic signed [DW-1:0] amp_a, amp_b;
   logic [TW-1:0]        tm_a, tm_b;
   logic [WB-1:0]        w_a, w_b;
   logic [15:0]          cnt_a, cnt_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pulse_peak_finder #(.DATA_WIDTH(DW), .TIME_WIDTH(TW), .WIDTH_BITS(WB),
                       .MAX_WIDTH(MAXW_A), .HOLDOFF_CYCLES(HOLD_A)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
      .input_data(input_data), .peak_valid(pv_a), .peak_amplitude(amp_a),
      .peak_time(tm_a), .peak_width(w_a), .peak_overflow(ov_a),
      .busy(bsy_a), .event_count(cnt_a));

   pulse_peak_finder #(.DATA_WIDTH(DW), .TIME_WIDTH(TW), .WIDTH_BITS(WB),
                       .MAX_WIDTH(MAXW_B), .HOLDOFF_CYCLES(HOLD_B)) dut_b (
      .clk(clk), .reset(reset), .enable(enable), .threshold(threshold),
      .input_data(input_data), .peak_valid(pv_b), .peak_amplitude(amp_b),
      .peak_time(tm_b), .peak_width(w_b), .peak_overflow(ov_b),
      .busy(bsy_b), .event_count(cnt_b));

   // Reference model state, one slot per instance.
   int                   maxw [2] = '{MAXW_A, MAXW_B};
   int                   hold [2] = '{HOLD_A, HOLD_B};
   int                   m_phase [2] = '{P_IDLE, P_IDLE};
   int                   m_left [2] = '{0, 0};
   int                   m_w [2] = '{0, 0};
   logic signed [DW-1:0] m_max [2];
   logic [TW-1:0]        m_maxt [2];
   logic                 m_valid [2] = '{1'b0, 1'b0};
   logic signed [DW-1:0] m_amp [2] = '{'0, '0};
   logic [TW-1:0]        m_time [2] = '{'0, '0};
   logic [WB-1:0]        m_width [2] = '{'0, '0};
   logic                 m_ovf [2] = '{1'b0, 1'b0};
   logic [15:0]          m_cnt [2] = '{'0, '0};
   logic [TW-1:0]        m_ts = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic end_pulse(input int k);
      if (hold[k] == 0) m_phase[k] = P_IDLE;
      else begin
         m_phase[k] = P_HOLD;
         m_left[k]  = hold[k];
      end
   endtask

   task automatic emit(input int k, input logic ovf);
      m_valid[k] = 1'b1;
      m_amp[k]   = m_max[k];
      m_time[k]  = m_maxt[k];
      m_width[k] = WB'(m_w[k]);
      m_ovf[k]   = ovf;
      m_cnt[k]   = m_cnt[k] + 16'd1;
      if (ovf) m_phase[k] = P_WAIT;
      else end_pulse(k);
   endtask

   // Effect of one clock edge on instance k; m_ts is the timestamp this edge samples.
   task automatic model_edge(input int k, input logic signed [DW-1:0] s,
                             input logic signed [DW-1:0] t, input bit e, input bit r);
      bit ab;
      ab = (s > t);
      m_valid[k] = 1'b0;
      if (r) begin
         m_phase[k] = P_IDLE;
         m_amp[k] = '0; m_time[k] = '0; m_width[k] = '0; m_ovf[k] = 1'b0; m_cnt[k] = '0;
      end else if (!e) begin
         m_phase[k] = P_IDLE;
      end else begin
         case (m_phase[k])
            P_IDLE: if (ab) begin
               m_max[k] = s; m_maxt[k] = m_ts; m_w[k] = 1;
               if (maxw[k] == 1) emit(k, 1'b1);
               else m_phase[k] = P_ABOVE;
            end
            P_ABOVE: if (ab) begin
               m_w[k] = m_w[k] + 1;
               if (s > m_max[k]) begin m_max[k] = s; m_maxt[k] = m_ts; end
               if (m_w[k] == maxw[k]) emit(k, 1'b1);
            end else emit(k, 1'b0);
            P_WAIT: if (!ab) end_pulse(k);
            default: begin
               m_left[k] = m_left[k] - 1;
               if (m_left[k] == 0) m_phase[k] = P_IDLE;
            end
         endcase
      end
   endtask

   task automatic check_dut(input int k, input logic pv, input logic signed [DW-1:0] amp,
                            input logic [TW-1:0] tm, input logic [WB-1:0] w, input logic ov,
                            input logic bsy, input logic [15:0] cnt);
      string n;
      n = (k == 0) ? "a" : "b";
      chk({n, ".peak_valid"},     64'(pv),  64'(m_valid[k]));
      chk({n, ".peak_amplitude"}, 64'(amp), 64'(m_amp[k]));
      chk({n, ".peak_time"},      64'(tm),  64'(m_time[k]));
      chk({n, ".peak_width"},     64'(w),   64'(m_width[k]));
      chk({n, ".peak_overflow"},  64'(ov),  64'(m_ovf[k]));
      chk({n, ".busy"},           64'(bsy), 64'(m_phase[k] != P_IDLE));
      chk({n, ".event_count"},    64'(cnt), 64'(m_cnt[k]));
   endtask

   task automatic step(input logic signed [DW-1:0] s, input logic signed [DW-1:0] t,
                       input bit e, input bit r);
      input_data = s; threshold = t; enable = e; reset = r;
      @(posedge clk);
      model_edge(0, s, t, e, r);
      model_edge(1, s, t, e, r);
      if (r) m_ts = '0;
      else m_ts = m_ts + TW'(1);
      #1;
      check_dut(0, pv_a, amp_a, tm_a, w_a, ov_a, bsy_a, cnt_a);
      check_dut(1, pv_b, amp_b, tm_b, w_b, ov_b, bsy_b, cnt_b);
   endtask

   task automatic quiet(input int n, input logic signed [DW-1:0] s, input logic signed [DW-1:0] t);
      for (int i = 0; i < n; i++) step(s, t, 1'b1, 1'b0);
   endtask

   initial begin
      logic [TW-1:0] t_first;
      int v, thr_r;
      bit e, r;
      int s1 [8] = '{0, 50, 150, 300, 250, 120, 90, 0};
      int s2 [5] = '{150, 300, 300, 200, 50};
      int s5 [4] = '{-100, -20, -10, -60};

      // Reset state
      for (int i = 0; i < 3; i++) step(16'sd0, 16'sd100, 1'b1, 1'b1);
      chk("rst.valid", 64'(pv_a), 64'(0));
      chk("rst.count", 64'(cnt_a), 64'(0));
      chk("rst.busy", 64'(bsy_a), 64'(0));

      // Simple pulse: strobe right after the 90
      for (int i = 0; i < 7; i++) step(DW'(s1[i]), 16'sd100, 1'b1, 1'b0);
      chk("t1.valid", 64'(pv_a), 64'(1));
      chk("t1.amp", 64'(amp_a), 64'(300));
      chk("t1.width", 64'(w_a), 64'(4));
      chk("t1.ovf", 64'(ov_a), 64'(0));
      chk("t1.count", 64'(cnt_a), 64'(1));
      step(DW'(s1[7]), 16'sd100, 1'b1, 1'b0);
      chk("t1.strobe_one_cycle", 64'(pv_a), 64'(0));
      quiet(20, 16'sd0, 16'sd100);

      // Plateau: peak time is the first of the tied maxima
      for (int i = 0; i < 5; i++) begin
         if (i == 1) t_first = m_ts;
         step(DW'(s2[i]), 16'sd100, 1'b1, 1'b0);
      end
      chk("t2.amp", 64'(amp_a), 64'(300));
      chk("t2.time", 64'(tm_a), 64'(t_first));
      chk("t2.count", 64'(cnt_a), 64'(2));
      quiet(20, 16'sd0, 16'sd100);

      // Overflow at the 8th sample, no second record, then holdoff
      for (int i = 0; i < 20; i++) begin
         step(16'sd500, 16'sd100, 1'b1, 1'b0);
         if (i == 7) begin
            chk("t3.valid", 64'(pv_a), 64'(1));
            chk("t3.width", 64'(w_a), 64'(8));
            chk("t3.ovf", 64'(ov_a), 64'(1));
         end
      end
      quiet(10, 16'sd0, 16'sd100);
      chk("t3.busy_in_holdoff", 64'(bsy_a), 64'(1));
      quiet(10, 16'sd0, 16'sd100);
      chk("t3.count", 64'(cnt_a), 64'(3));

      // Holdoff: pulses 10 apart -> one record, 30 apart -> two
      quiet(3, 16'sd200, 16'sd100); quiet(7, 16'sd0, 16'sd100);
      quiet(3, 16'sd200, 16'sd100); quiet(40, 16'sd0, 16'sd100);
      chk("t4.close_pair", 64'(cnt_a), 64'(4));
      quiet(3, 16'sd200, 16'sd100); quiet(27, 16'sd0, 16'sd100);
      quiet(3, 16'sd200, 16'sd100); quiet(30, 16'sd0, 16'sd100);
      chk("t4.far_pair", 64'(cnt_a), 64'(6));

      // Negative threshold
      for (int i = 0; i < 4; i++) step(DW'(s5[i]), -16'sd50, 1'b1, 1'b0);
      chk("t5.amp", 64'(amp_a), 64'(-10));
      chk("t5.width", 64'(w_a), 64'(2));
      quiet(20, -16'sd100, -16'sd50);

      // Reset mid-pulse
      quiet(2, 16'sd300, 16'sd100);
      step(16'sd300, 16'sd100, 1'b1, 1'b1);
      chk("t6.rst_valid", 64'(pv_a), 64'(0));
      chk("t6.rst_count", 64'(cnt_a), 64'(0));
      quiet(2, 16'sd0, 16'sd100);
      step(16'sd300, 16'sd100, 1'b1, 1'b0); step(16'sd200, 16'sd100, 1'b1, 1'b0);
      step(16'sd0, 16'sd100, 1'b1, 1'b0);
      chk("t6.after_rst", 64'(cnt_a), 64'(1));
      quiet(20, 16'sd0, 16'sd100);

      // Enable dropped mid-pulse, re-enabled while above
      quiet(2, 16'sd300, 16'sd100);
      step(16'sd300, 16'sd100, 1'b0, 1'b0);
      chk("t6.en_valid", 64'(pv_a), 64'(0));
      chk("t6.en_busy", 64'(bsy_a), 64'(0));
      step(16'sd300, 16'sd100, 1'b1, 1'b0);
      step(16'sd0, 16'sd100, 1'b1, 1'b0);
      chk("t6.en_width", 64'(w_a), 64'(1));
      chk("t6.en_count", 64'(cnt_a), 64'(2));
      quiet(20, 16'sd0, 16'sd100);

      // Pulse straddling the timestamp wrap
      for (int i = 0; i < 300 && m_ts != TW'(254); i++) step(16'sd0, 16'sd100, 1'b1, 1'b0);
      step(16'sd150, 16'sd100, 1'b1, 1'b0); step(16'sd300, 16'sd100, 1'b1, 1'b0);
      step(16'sd150, 16'sd100, 1'b1, 1'b0); step(16'sd0, 16'sd100, 1'b1, 1'b0);
      chk("t6.wrap_time", 64'(tm_a), 64'(8'hFF));
      quiet(20, 16'sd0, 16'sd100);

      // Random traffic against the model
      thr_r = 100;
      for (int i = 0; i < 1500; i++) begin
         v = int'($urandom_range(0, 600)) - 200;
         if (i % 200 == 199) thr_r = int'($urandom_range(0, 300)) - 150;
         e = ($urandom_range(0, 39) != 0);
         r = ($urandom_range(0, 299) == 0);
         step(DW'(v), DW'(thr_r), e, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
